// File: rtl/trace_pkg.sv
// Shared definitions for the bus trace buffer.
// Holds the record kind codes, the capture state codes and the field widths
// that the top level and the record FIFO both use.
// Kind classification is a function so that every user applies the same
// priority: a fetch is a fetch, otherwise a nonzero strobe makes a write.
package trace_pkg;

    localparam int KIND_W  = 2;
    localparam int STATE_W = 2;

    localparam logic [KIND_W-1:0] KIND_IFETCH = 2'd0;
    localparam logic [KIND_W-1:0] KIND_READ   = 2'd1;
    localparam logic [KIND_W-1:0] KIND_WRITE  = 2'd2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_PRE  = 2'd1;
    localparam logic [STATE_W-1:0] ST_POST = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

    function automatic logic [KIND_W-1:0] kind_of(input logic fetch, input logic is_write);
        if (fetch)
            return KIND_IFETCH;
        else if (is_write)
            return KIND_WRITE;
        else
            return KIND_READ;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the bus trace buffer.
// DEPTH x REC_W record RAM with read/write pointers and an occupancy count.
// With overwrite high a write into a full FIFO replaces the oldest entry
// (read pointer advances, occupancy stays at DEPTH); with overwrite low the
// write is ignored and the caller accounts for the drop.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               empty the FIFO (pointers and occupancy to zero)
//   wr_en, wr_rec       push a record
//   overwrite           allow a push into a full FIFO to evict the oldest
//   rd_en               pop the oldest record (ignored when empty)
//   rd_rec              oldest record, combinational from the RAM
//   occupancy           entries held, 0..DEPTH
module trace_fifo #(
    parameter int REC_W = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic                       overwrite,
    input  logic [REC_W-1:0]           wr_rec,
    input  logic                       rd_en,
    output logic [REC_W-1:0]           rd_rec,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             evict;

    assign full   = (occupancy == FULL_OCC);
    assign empty  = (occupancy == '0);
    assign push   = wr_en & ~clear & (~full | overwrite);
    assign pop    = rd_en & ~clear & ~empty;
    // A push into a full FIFO without a simultaneous pop evicts the oldest entry.
    assign evict  = push & full & ~pop;
    assign rd_rec = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop | evict)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop & ~full)
                occupancy <= occupancy + 1'b1;
            else if (pop & ~push)
                occupancy <= occupancy - 1'b1;
        end
    end

    // Record storage carries no reset; occupancy guards against stale reads.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_rec;
    end

endmodule

// File: rtl/bus_trace_buffer.sv
// CPU bus tracer: snoops completed transfers (ifetch/read/write), stores
// qualified records around an address trigger and drains them through a
// valid/ready read port while idle or done.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a free-running timestamp
// stored with each record and presented on rd_ts.
// Ports:
//   sys_clk, sys_reset          clock, asynchronous active-high reset
//   cpu_*/sys_rw_is_done        snooped CPU bus; record point is rw_cycle & is_done
//   arm                         clear buffer and counters, start capture (PRE)
//   kind_en                     capture enables {write, read, ifetch}
//   trig_addr, trig_mask        trigger compare (mask bit 1 = compared)
//   post_count                  records kept after the trigger record
//   rd_valid/rd_ready, rd_*     oldest-record read port
//   state, occupancy, drop_cnt  status
module bus_trace_buffer
    import trace_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 24
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  cpu_rw_cycle,
    input  logic                  sys_rw_is_done,
    input  logic                  cpu_instr_fetch,
    input  logic [DATA_W/8-1:0]   cpu_write_strobe,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic [DATA_W-1:0]     cpu_write_data,
    input  logic [DATA_W-1:0]     cpu_read_data,
    input  logic                  arm,
    input  logic [2:0]            kind_en,
    input  logic [ADDR_W-1:0]     trig_addr,
    input  logic [ADDR_W-1:0]     trig_mask,
    input  logic [CNT_W-1:0]      post_count,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [KIND_W-1:0]     rd_kind,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DATA_W/8-1:0]   rd_strb,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]       rd_ts,
`endif
    output logic [STATE_W-1:0]    state,
    output logic [CNT_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int STRB_W = DATA_W/8;
    localparam int OCC_W  = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W  = KIND_W + ADDR_W + DATA_W + STRB_W + TS_W;
`else
    localparam int REC_W  = KIND_W + ADDR_W + DATA_W + STRB_W;
`endif
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [KIND_W-1:0] kind;
    logic              kind_ok;
    logic              qualified;
    logic              hit;
    logic [DATA_W-1:0] rec_data;
    logic [STRB_W-1:0] rec_strb;
    logic [REC_W-1:0]  wr_rec;
    logic [REC_W-1:0]  head;
    logic [OCC_W-1:0]  occ;
    logic              full;
    logic              capturing;
    logic              wr_en;
    logic              rd_en;
    logic [CNT_W-1:0]  post_cnt;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset)
            ts <= '0;
        else
            ts <= ts + 1'b1;
    end
`endif

    always_comb begin
        kind = kind_of(cpu_instr_fetch, |cpu_write_strobe);
        case (kind)
            KIND_IFETCH: kind_ok = kind_en[0];
            KIND_READ:   kind_ok = kind_en[1];
            KIND_WRITE:  kind_ok = kind_en[2];
            default:     kind_ok = 1'b0;
        endcase
    end

    assign qualified = cpu_rw_cycle & sys_rw_is_done & kind_ok;
    assign hit       = qualified & (((cpu_address ^ trig_addr) & trig_mask) == '0);
    assign rec_data  = (kind == KIND_WRITE) ? cpu_write_data : cpu_read_data;
    assign rec_strb  = (kind == KIND_WRITE) ? cpu_write_strobe : '0;

`ifdef TRACE_TIMESTAMP_EN
    assign wr_rec = {kind, cpu_address, rec_data, rec_strb, ts};
`else
    assign wr_rec = {kind, cpu_address, rec_data, rec_strb};
`endif

    assign capturing = (state == ST_PRE) || (state == ST_POST);
    assign full      = (occ == FULL_OCC);
    // arm takes priority: the same-cycle record and any pop are discarded.
    assign wr_en     = ~arm & qualified & capturing;
    assign rd_valid  = ~capturing & (occ != '0);
    assign rd_en     = ~arm & rd_valid & rd_ready;
    assign occupancy = CNT_W'(occ);

    trace_fifo #(
        .REC_W (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_reset),
        .clear     (arm),
        .wr_en     (wr_en),
        .overwrite (state == ST_PRE),
        .wr_rec    (wr_rec),
        .rd_en     (rd_en),
        .rd_rec    (head),
        .occupancy (occ)
    );

    // Read port shows zeros unless a record is actually available.
    always_comb begin
        rd_kind = '0;
        rd_addr = '0;
        rd_data = '0;
        rd_strb = '0;
`ifdef TRACE_TIMESTAMP_EN
        rd_ts   = '0;
        if (rd_valid)
            {rd_kind, rd_addr, rd_data, rd_strb, rd_ts} = head;
`else
        if (rd_valid)
            {rd_kind, rd_addr, rd_data, rd_strb} = head;
`endif
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state    <= ST_IDLE;
            post_cnt <= '0;
            drop_cnt <= '0;
        end else if (arm) begin
            state    <= ST_PRE;
            post_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            case (state)
                ST_PRE: begin
                    if (hit) begin
                        post_cnt <= post_count;
                        state    <= (post_count == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (qualified) begin
                        // Counter runs down whether the record fits or is dropped.
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == CNT_W'(1))
                            state <= ST_DONE;
                        if (full && (drop_cnt != '1))
                            drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_trace_buffer.sv
module tb_bus_trace_buffer;
    import trace_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        cpu_rw_cycle;
    logic        sys_rw_is_done;
    logic        cpu_instr_fetch;
    logic [3:0]  cpu_write_strobe;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        arm;
    logic [2:0]  kind_en;
    logic [31:0] trig_addr;
    logic [31:0] trig_mask;
    logic [15:0] post_count;
    logic        rd_valid;
    logic        rd_ready;
    logic [1:0]  rd_kind;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  rd_strb;
    logic [1:0]  state;
    logic [15:0] occupancy;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    bus_trace_buffer dut (
        .sys_clk          (sys_clk),
        .sys_reset        (sys_reset),
        .cpu_rw_cycle     (cpu_rw_cycle),
        .sys_rw_is_done   (sys_rw_is_done),
        .cpu_instr_fetch  (cpu_instr_fetch),
        .cpu_write_strobe (cpu_write_strobe),
        .cpu_address      (cpu_address),
        .cpu_write_data   (cpu_write_data),
        .cpu_read_data    (cpu_read_data),
        .arm              (arm),
        .kind_en          (kind_en),
        .trig_addr        (trig_addr),
        .trig_mask        (trig_mask),
        .post_count       (post_count),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_kind          (rd_kind),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .rd_strb          (rd_strb),
        .state            (state),
        .occupancy        (occupancy),
        .drop_cnt         (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        fetch;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [1:0]  exp_state;
        logic [15:0] exp_occ;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic bus(input logic f, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdv);
        cpu_rw_cycle     = 1'b1;
        sys_rw_is_done   = 1'b1;
        cpu_instr_fetch  = f;
        cpu_write_strobe = s;
        cpu_address      = a;
        cpu_write_data   = wd;
        cpu_read_data    = rdv;
        tick();
        cpu_rw_cycle     = 1'b0;
        sys_rw_is_done   = 1'b0;
        cpu_instr_fetch  = 1'b0;
        cpu_write_strobe = '0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pop();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held_addr;
        logic [31:0] held_data;

        sys_reset = 1'b1;
        cpu_rw_cycle = 0; sys_rw_is_done = 0; cpu_instr_fetch = 0;
        cpu_write_strobe = '0; cpu_address = '0; cpu_write_data = '0; cpu_read_data = '0;
        arm = 0; kind_en = 3'b111; trig_addr = '0; trig_mask = '0; post_count = '0;
        rd_ready = 0;

        tbl[0] = '{1'b1, 4'h0, 32'h0000_0000, ST_POST, 16'd1};
        tbl[1] = '{1'b1, 4'h0, 32'h0000_0004, ST_POST, 16'd2};
        tbl[2] = '{1'b1, 4'h0, 32'h0000_0008, ST_POST, 16'd3};
        tbl[3] = '{1'b1, 4'h0, 32'h0000_000C, ST_DONE, 16'd4};
        tbl[4] = '{1'b1, 4'h0, 32'h0000_0010, ST_DONE, 16'd4};

        // 1: reset state, then fetches without arm
        tick(); tick();
        chk("rst_state", state, ST_IDLE);
        chk("rst_occ", occupancy, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_addr", rd_addr, 0);
        sys_reset = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) bus(1'b1, 4'h0, 32'h100 + 4*i, 0, 32'hA000 + i);
        chk("noarm_state", state, ST_IDLE);
        chk("noarm_occ", occupancy, 0);
        chk("noarm_valid", rd_valid, 0);

        // 2: always-hit trigger, post_count 3, table-driven
        kind_en = 3'b111; trig_mask = '0; post_count = 16'd3;
        do_arm();
        chk("arm_state", state, ST_PRE);
        chk("arm_occ", occupancy, 0);
        for (int i = 0; i < 5; i++) begin
            bus(tbl[i].fetch, tbl[i].strb, tbl[i].addr, 0, 32'hF000 + i);
            chk($sformatf("t2_state%0d", i), state, tbl[i].exp_state);
            chk($sformatf("t2_occ%0d", i), occupancy, tbl[i].exp_occ);
            if (i < 3) chk($sformatf("t2_novalid%0d", i), rd_valid, 0);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_valid%0d", i), rd_valid, 1);
            chk($sformatf("t2_addr%0d", i), rd_addr, tbl[i].addr);
            chk($sformatf("t2_kind%0d", i), rd_kind, KIND_IFETCH);
            chk($sformatf("t2_data%0d", i), rd_data, 32'hF000 + i);
            pop();
        end
        chk("t2_empty", rd_valid, 0);
        chk("t2_occ_end", occupancy, 0);

        // 3: pre-trigger overwrite, hit at 0x100, post_count 0
        kind_en = 3'b111; trig_addr = 32'h100; trig_mask = '1; post_count = 0;
        do_arm();
        for (int i = 0; i < 20; i++) bus(1'b0, 4'h0, 4*i, 0, i);
        chk("t3_pre_state", state, ST_PRE);
        chk("t3_pre_occ", occupancy, 16);
        bus(1'b0, 4'h0, 32'h100, 0, 32'h77);
        chk("t3_state", state, ST_DONE);
        chk("t3_occ", occupancy, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_addr%0d", i), rd_addr, (i == 15) ? 32'h100 : 32'h14 + 4*i);
            if (i == 0) chk("t3_kind", rd_kind, KIND_READ);
            pop();
        end
        chk("t3_empty", rd_valid, 0);

        // 4: post_count 20 into empty buffer -> 5 drops; then hold test (6)
        trig_addr = 32'h200; trig_mask = '1; post_count = 16'd20;
        do_arm();
        bus(1'b0, 4'h0, 32'h200, 0, 0);
        chk("t4_hit_state", state, ST_POST);
        for (int i = 0; i < 19; i++) bus(1'b0, 4'h0, 32'h300 + 4*i, 0, 0);
        chk("t4_state19", state, ST_POST);
        chk("t4_drop19", drop_cnt, 4);
        bus(1'b0, 4'h0, 32'h400, 0, 0);
        chk("t4_state", state, ST_DONE);
        chk("t4_occ", occupancy, 16);
        chk("t4_drop", drop_cnt, 5);
        bus(1'b0, 4'h0, 32'h404, 0, 0);
        chk("t4_frozen_occ", occupancy, 16);
        chk("t4_frozen_drop", drop_cnt, 5);
        chk("t4_first", rd_addr, 32'h200);
        held_addr = rd_addr;
        held_data = rd_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_hold_addr%0d", i), rd_addr, held_addr);
            chk($sformatf("t6_hold_data%0d", i), rd_data, held_data);
            chk($sformatf("t6_hold_occ%0d", i), occupancy, 16);
        end
        pop();
        chk("t4_second", rd_addr, 32'h300);
        chk("t4_occ_pop", occupancy, 15);

        // 5: writes only
        kind_en = 3'b100; trig_mask = '0; post_count = 0;
        do_arm();
        bus(1'b1, 4'h0, 32'h0, 0, 32'h1111);
        bus(1'b0, 4'h0, 32'h4, 0, 32'h2222);
        bus(1'b1, 4'h0, 32'h8, 0, 32'h3333);
        chk("t5_pre_occ", occupancy, 0);
        bus(1'b0, 4'h1, 32'h1000_0000, 32'h55, 32'hDEAD);
        bus(1'b1, 4'h0, 32'hC, 0, 32'h4444);
        chk("t5_state", state, ST_DONE);
        chk("t5_occ", occupancy, 1);
        chk("t5_kind", rd_kind, KIND_WRITE);
        chk("t5_addr", rd_addr, 32'h1000_0000);
        chk("t5_strb", rd_strb, 4'h1);
        chk("t5_data", rd_data, 32'h55);

        // 6: arm mid-POST with drops pending and a same-cycle record
        kind_en = 3'b111; trig_mask = '0; post_count = 16'd30;
        do_arm();
        for (int i = 0; i < 21; i++) bus(1'b1, 4'h0, 32'h800 + 4*i, 0, 0);
        chk("t6_post_state", state, ST_POST);
        chk("t6_post_drop", drop_cnt, 5);
        chk("t6_post_valid", rd_valid, 0);
        arm = 1'b1;
        rd_ready = 1'b1;
        bus(1'b1, 4'h0, 32'h900, 0, 0);
        arm = 1'b0;
        rd_ready = 1'b0;
        chk("t6_rearm_state", state, ST_PRE);
        chk("t6_rearm_occ", occupancy, 0);
        chk("t6_rearm_drop", drop_cnt, 0);
        bus(1'b1, 4'h0, 32'h904, 0, 0);
        chk("t6_after_occ", occupancy, 1);
        chk("t6_after_state", state, ST_POST);

        // reset mid-capture
        sys_reset = 1'b1;
        #2;
        chk("rst2_state", state, ST_IDLE);
        chk("rst2_occ", occupancy, 0);
        chk("rst2_valid", rd_valid, 0);
        sys_reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
